// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 decode constants, encodings and stage types
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 1 << REG_AW;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Main decoder output, ordered as the control word is usually tabulated
  typedef struct packed {
    logic        reg_write;
    imm_src_e    imm_src;
    logic        alu_src;
    logic        mem_write;
    result_src_e result_src;
    logic        branch;
    alu_op_e     alu_op;
    logic        jump;
  } main_ctrl_t;

  // Contents of the D/E pipeline register
  typedef struct packed {
    logic              reg_write;
    result_src_e       result_src;
    logic              mem_write;
    logic              jump;
    logic              branch;
    alu_ctrl_e         alu_ctrl;
    logic              alu_src;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus4;
  } de_reg_t;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two read ports, one write port with bypass
module register_file
  import riscv_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Storage: cleared by reset, x0 never written
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: x0 reads zero, a same-cycle write is forwarded
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    if (raddr1_i == '0)                      rdata1_o = '0;
    else if (we_i && (waddr_i == raddr1_i))  rdata1_o = wdata_i;
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rdata2_o = regs_q[raddr2_i];
    if (raddr2_i == '0)                      rdata2_o = '0;
    else if (we_i && (waddr_i == raddr2_i))  rdata2_o = wdata_i;
  end

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32 decode stage with register file and D/E pipeline register
module decode_cycle
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   InstrD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              FlushE,
  output logic              RegWriteE,
  output logic [1:0]        ResultSrcE,
  output logic              MemWriteE,
  output logic              JumpE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic              ALUSrcE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  main_ctrl_t      ctrl;
  alu_ctrl_e       alu_ctrl;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  de_reg_t         de_d;
  de_reg_t         de_q;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7_5 = InstrD[30];

  register_file u_register_file (
    .clk_i    (clk),
    .rst_ni   (reset),
    .raddr1_i (InstrD[19:15]),
    .raddr2_i (InstrD[24:20]),
    .we_i     (RegWriteW),
    .waddr_i  (RDW),
    .wdata_i  (ResultW),
    .rdata1_o (rd1),
    .rdata2_o (rd2)
  );

  // Main control decode; unknown opcodes become a bubble
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl.imm_src   = IMM_S;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.imm_src = IMM_B;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALUOP_SUB;
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  // ALU operation select; bit 30 only means subtract for register-register ops
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (ctrl.alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (opcode[5] && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // Immediate generation, always sign-extended from bit 31
  always_comb begin
    imm_ext = '0;
    case (ctrl.imm_src)
      IMM_I: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_ext = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // Next D/E contents; a flush loads an all-zero bubble
  always_comb begin
    de_d = '0;
    if (!FlushE) begin
      de_d.reg_write  = ctrl.reg_write;
      de_d.result_src = ctrl.result_src;
      de_d.mem_write  = ctrl.mem_write;
      de_d.jump       = ctrl.jump;
      de_d.branch     = ctrl.branch;
      de_d.alu_ctrl   = alu_ctrl;
      de_d.alu_src    = ctrl.alu_src;
      de_d.rd1        = rd1;
      de_d.rd2        = rd2;
      de_d.imm_ext    = imm_ext;
      de_d.rs1        = InstrD[19:15];
      de_d.rs2        = InstrD[24:20];
      de_d.rd         = InstrD[11:7];
      de_d.pc         = PCD;
      de_d.pc_plus4   = PCPlus4D;
    end
  end

  // D/E pipeline register; reset discards whatever is in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) de_q <= '0;
    else        de_q <= de_d;
  end

  assign RegWriteE   = de_q.reg_write;
  assign ResultSrcE  = de_q.result_src;
  assign MemWriteE   = de_q.mem_write;
  assign JumpE       = de_q.jump;
  assign BranchE     = de_q.branch;
  assign ALUControlE = de_q.alu_ctrl;
  assign ALUSrcE     = de_q.alu_src;
  assign RD1E        = de_q.rd1;
  assign RD2E        = de_q.rd2;
  assign ImmExtE     = de_q.imm_ext;
  assign Rs1E        = de_q.rs1;
  assign Rs2E        = de_q.rs2;
  assign RdE         = de_q.rd;
  assign PCE         = de_q.pc;
  assign PCPlus4E    = de_q.pc_plus4;

endmodule

// File: tb/tb_decode_cycle.sv
// tb/tb_decode_cycle.sv - self-checking bench for decode_cycle
module tb_decode_cycle;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        jp;
    logic        br;
    logic [2:0]  alu;
    logic        as;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic        rww;
    logic [4:0]  rdw;
    logic [31:0] resw;
    logic        flush;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] InstrD = '0;
  logic [31:0] PCD = '0;
  logic [31:0] PCPlus4D = '0;
  logic        RegWriteW = 1'b0;
  logic [4:0]  RDW = '0;
  logic [31:0] ResultW = '0;
  logic        FlushE = 1'b0;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] ImmExtE;
  logic [4:0]  Rs1E;
  logic [4:0]  Rs2E;
  logic [4:0]  RdE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  vec_t vecs[$];

  decode_cycle dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".RegWriteE"},   32'(RegWriteE),   32'(e.rw));
    chk({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(e.rs));
    chk({tag, ".MemWriteE"},   32'(MemWriteE),   32'(e.mw));
    chk({tag, ".JumpE"},       32'(JumpE),       32'(e.jp));
    chk({tag, ".BranchE"},     32'(BranchE),     32'(e.br));
    chk({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(e.alu));
    chk({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(e.as));
    chk({tag, ".RD1E"},        RD1E,             e.rd1);
    chk({tag, ".RD2E"},        RD2E,             e.rd2);
    chk({tag, ".ImmExtE"},     ImmExtE,          e.imm);
    chk({tag, ".Rs1E"},        32'(Rs1E),        32'(e.rs1));
    chk({tag, ".Rs2E"},        32'(Rs2E),        32'(e.rs2));
    chk({tag, ".RdE"},         32'(RdE),         32'(e.rd));
    chk({tag, ".PCE"},         PCE,              e.pc);
    chk({tag, ".PCPlus4E"},    PCPlus4E,         e.pc4);
  endtask

  function automatic vec_t mk(
    input logic [31:0] instr, input logic rww, input logic [4:0] rdw,
    input logic [31:0] resw, input logic flush,
    input logic rw, input logic [1:0] rs, input logic mw, input logic jp,
    input logic br, input logic [2:0] alu, input logic as,
    input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
    input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    vec_t v;
    v.instr = instr; v.rww = rww; v.rdw = rdw; v.resw = resw; v.flush = flush;
    v.e.rw = rw; v.e.rs = rs; v.e.mw = mw; v.e.jp = jp; v.e.br = br;
    v.e.alu = alu; v.e.as = as; v.e.rd1 = rd1; v.e.rd2 = rd2; v.e.imm = imm;
    v.e.rs1 = rs1; v.e.rs2 = rs2; v.e.rd = rd; v.e.pc = '0; v.e.pc4 = '0;
    return v;
  endfunction

  // Called at a negedge: drive, record expectation, check one edge later
  task automatic drive(input string tag, input vec_t v, input logic [31:0] pc);
    exp_t e;
    InstrD = v.instr; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = v.rww; RDW = v.rdw; ResultW = v.resw; FlushE = v.flush;
    e = v.e;
    e.pc  = v.flush ? 32'h0 : pc;
    e.pc4 = v.flush ? 32'h0 : pc + 32'd4;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total_cnt++;
      $display("FAIL %s.scoreboard: got empty queue, expected one entry", tag);
    end else begin
      check_out(tag, sb.pop_front());
    end
    @(negedge clk);
    RegWriteW = 1'b0; FlushE = 1'b0;
  endtask

  initial begin
    exp_t zero;
    zero = mk(32'h0, N, 5'd0, 32'h0, N, N, 2'b00, N, N, N, 3'b000, N,
              32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0).e;

    //          instr          rww rdw    resw          fl  rw rs     mw jp br alu     as  rd1           rd2           imm           rs1    rs2    rd
    vecs.push_back(mk(32'h00700293, N, 5'd0, 32'h0,      N, Y, 2'b00, N, N, N, 3'b000, Y, 32'h0,      32'h0,      32'h7,        5'd0, 5'd7,  5'd5));
    vecs.push_back(mk(32'h006283B3, Y, 5'd5, 32'h1234,   N, Y, 2'b00, N, N, N, 3'b000, N, 32'h1234,   32'h0,      32'h6,        5'd5, 5'd6,  5'd7));
    vecs.push_back(mk(32'h40628433, Y, 5'd6, 32'hCAFE,   N, Y, 2'b00, N, N, N, 3'b001, N, 32'h1234,   32'hCAFE,   32'h406,      5'd5, 5'd6,  5'd8));
    vecs.push_back(mk(32'h00700293, Y, 5'd0, 32'hDEAD,   N, Y, 2'b00, N, N, N, 3'b000, Y, 32'h0,      32'h0,      32'h7,        5'd0, 5'd7,  5'd5));
    vecs.push_back(mk(32'h00612423, N, 5'd0, 32'h0,      N, N, 2'b00, Y, N, N, 3'b000, Y, 32'h0,      32'hCAFE,   32'h8,        5'd2, 5'd6,  5'd8));
    vecs.push_back(mk(32'hFE000EE3, N, 5'd0, 32'h0,      N, N, 2'b00, N, N, Y, 3'b001, N, 32'h0,      32'h0,      32'hFFFFFFFC, 5'd0, 5'd0,  5'd29));
    vecs.push_back(mk(32'hFFC2A483, N, 5'd0, 32'h0,      N, Y, 2'b01, N, N, N, 3'b000, Y, 32'h1234,   32'h0,      32'hFFFFFFFC, 5'd5, 5'd28, 5'd9));
    vecs.push_back(mk(32'h008000EF, N, 5'd0, 32'h0,      N, Y, 2'b10, N, Y, N, 3'b000, N, 32'h0,      32'h0,      32'h8,        5'd0, 5'd8,  5'd1));
    vecs.push_back(mk(32'h0062A533, N, 5'd0, 32'h0,      N, Y, 2'b00, N, N, N, 3'b101, N, 32'h1234,   32'hCAFE,   32'h6,        5'd5, 5'd6,  5'd10));
    vecs.push_back(mk(32'hFFF36593, N, 5'd0, 32'h0,      N, Y, 2'b00, N, N, N, 3'b011, Y, 32'hCAFE,   32'h0,      32'hFFFFFFFF, 5'd6, 5'd31, 5'd11));
    vecs.push_back(mk(32'h0F02F613, N, 5'd0, 32'h0,      N, Y, 2'b00, N, N, N, 3'b010, Y, 32'h1234,   32'h0,      32'hF0,       5'd5, 5'd16, 5'd12));
    vecs.push_back(mk(32'h006296B3, N, 5'd0, 32'h0,      N, Y, 2'b00, N, N, N, 3'b000, N, 32'h1234,   32'hCAFE,   32'h6,        5'd5, 5'd6,  5'd13));
    vecs.push_back(mk(32'h0062807F, N, 5'd0, 32'h0,      N, N, 2'b00, N, N, N, 3'b000, N, 32'h1234,   32'hCAFE,   32'h6,        5'd5, 5'd6,  5'd0));
    vecs.push_back(mk(32'h006283B3, Y, 5'd7, 32'h77,     Y, N, 2'b00, N, N, N, 3'b000, N, 32'h0,      32'h0,      32'h0,        5'd0, 5'd0,  5'd0));
    vecs.push_back(mk(32'h00038713, N, 5'd0, 32'h0,      N, Y, 2'b00, N, N, N, 3'b000, Y, 32'h77,     32'h0,      32'h0,        5'd7, 5'd0,  5'd14));
    vecs.push_back(mk(32'h40000793, N, 5'd0, 32'h0,      N, Y, 2'b00, N, N, N, 3'b000, Y, 32'h0,      32'h0,      32'h400,      5'd0, 5'd0,  5'd15));

    // Asynchronous reset before any clock edge
    #1 reset = 1'b0;
    #1 check_out("reset_state", zero);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive($sformatf("vec%0d", i), vecs[i], 32'h100 + 32'(i) * 32'd4);
    end

    // Mid-operation reset between edges, with a write attempted under reset
    drive("pre_rst", mk(32'h006283B3, N, 5'd0, 32'h0, N, Y, 2'b00, N, N, N, 3'b000, N,
                        32'h1234, 32'hCAFE, 32'h6, 5'd5, 5'd6, 5'd7), 32'h200);
    @(posedge clk);
    #3;
    reset = 1'b0;
    RegWriteW = 1'b1; RDW = 5'd6; ResultW = 32'h5555;
    #1 check_out("async_rst", zero);
    repeat (2) @(posedge clk);
    #1 check_out("held_rst", zero);
    @(negedge clk);
    reset = 1'b1;
    RegWriteW = 1'b0;
    drive("post_rst", mk(32'h006283B3, N, 5'd0, 32'h0, N, Y, 2'b00, N, N, N, 3'b000, N,
                         32'h0, 32'h0, 32'h6, 5'd5, 5'd6, 5'd7), 32'h300);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
